// File: rtl/core_seq_ctrl.sv
// Instruction sequencer for one core tile: weight fetch, array load, activation
// fetch, execute and OFIFO drain (optional psum accumulate) onto the 34-bit inst bus.
module core_seq_ctrl #(
  parameter int ROW    = 8,
  parameter int COL    = 8,
  parameter int ADDR_W = 11,
  parameter int CNT_W  = 11
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] w_base,
  input  logic [ADDR_W-1:0] a_base,
  input  logic [ADDR_W-1:0] p_base,
  input  logic [CNT_W-1:0]  num_act,
  input  logic              acc_en,
  input  logic              ofifo_valid,
  output logic [33:0]       inst,
  output logic              busy,
  output logic              done
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_W_RD  = 3'd1;
  localparam logic [2:0] S_W_LD  = 3'd2;
  localparam logic [2:0] S_A_RD  = 3'd3;
  localparam logic [2:0] S_EXEC  = 3'd4;
  localparam logic [2:0] S_DRAIN = 3'd5;
  localparam logic [2:0] S_FIN   = 3'd6;

  localparam logic [33:0] IDLE_INST = 34'h1_800C_0000;

  logic [2:0]        state, n_state;
  logic [CNT_W-1:0]  cnt, n_cnt, cnt_inc, num_last;
  logic [CNT_W-1:0]  row, n_row, src_row;
  logic              phase, n_phase, src_phase;
  logic              n_done, drain_go;
  logic [ADDR_W-1:0] w_q, a_q, p_q;
  logic [CNT_W-1:0]  num_q;
  logic              acc_q;

  logic              f_acc, f_cen_p, f_wen_p, f_cen_x;
  logic              f_ofifo_rd, f_l0_rd, f_l0_wr, f_exec, f_load;
  logic [ADDR_W-1:0] f_a_p, f_a_x;
  logic [33:0]       n_inst;

  assign cnt_inc  = cnt + CNT_W'(1);
  assign num_last = num_q - CNT_W'(1);

  // Next-state logic also decides the instruction word for the coming cycle,
  // so inst is registered yet lines up with the state it belongs to.
  always_comb begin
    n_state    = state;
    n_cnt      = cnt;
    n_row      = row;
    n_phase    = phase;
    n_done     = 1'b0;
    drain_go   = 1'b0;
    src_row    = '0;
    src_phase  = 1'b0;
    f_acc      = 1'b0;
    f_cen_p    = 1'b1;
    f_wen_p    = 1'b1;
    f_a_p      = '0;
    f_cen_x    = 1'b1;
    f_a_x      = '0;
    f_ofifo_rd = 1'b0;
    f_l0_rd    = 1'b0;
    f_l0_wr    = 1'b0;
    f_exec     = 1'b0;
    f_load     = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          n_state = S_W_RD;
          n_cnt   = '0;
          f_cen_x = 1'b0;
          f_a_x   = w_base;
        end
      end
      S_W_RD: begin
        f_l0_wr = 1'b1;
        if (cnt == CNT_W'(ROW - 1)) begin
          n_state = S_W_LD;
          n_cnt   = '0;
          f_load  = 1'b1;
          f_l0_rd = 1'b1;
        end else begin
          n_cnt   = cnt_inc;
          f_cen_x = 1'b0;
          f_a_x   = w_q + ADDR_W'(cnt_inc);
        end
      end
      S_W_LD: begin
        if (cnt == CNT_W'(ROW + COL - 2)) begin
          n_cnt = '0;
          if (num_q == '0) begin
            n_state = S_FIN;
            n_done  = 1'b1;
          end else begin
            n_state = S_A_RD;
            f_cen_x = 1'b0;
            f_a_x   = a_q;
          end
        end else begin
          n_cnt   = cnt_inc;
          f_load  = 1'b1;
          f_l0_rd = (cnt_inc < CNT_W'(ROW));
        end
      end
      S_A_RD: begin
        f_l0_wr = 1'b1;
        if (cnt == num_last) begin
          n_state = S_EXEC;
          n_cnt   = '0;
          f_l0_rd = 1'b1;
          f_exec  = 1'b1;
        end else begin
          n_cnt   = cnt_inc;
          f_cen_x = 1'b0;
          f_a_x   = a_q + ADDR_W'(cnt_inc);
        end
      end
      S_EXEC: begin
        if (cnt == num_last) begin
          n_state  = S_DRAIN;
          n_cnt    = '0;
          drain_go = 1'b1;
        end else begin
          n_cnt   = cnt_inc;
          f_l0_rd = 1'b1;
          f_exec  = 1'b1;
        end
      end
      S_DRAIN: drain_go = 1'b1;
      S_FIN:   n_state  = S_IDLE;
      default: n_state  = S_IDLE;
    endcase

    // A pending accumulate write completes unconditionally; otherwise a row
    // only advances when the OFIFO has a full row ready.
    if (drain_go) begin
      src_row   = (state == S_DRAIN) ? row : '0;
      src_phase = (state == S_DRAIN) && phase;
      n_row     = src_row;
      n_phase   = src_phase;
      if (src_row == num_q) begin
        n_state = S_FIN;
        n_done  = 1'b1;
      end else if (src_phase || (ofifo_valid && !acc_q)) begin
        f_ofifo_rd = 1'b1;
        f_acc      = acc_q;
        f_cen_p    = 1'b0;
        f_wen_p    = 1'b0;
        f_a_p      = p_q + ADDR_W'(src_row);
        n_row      = src_row + CNT_W'(1);
        n_phase    = 1'b0;
      end else if (ofifo_valid) begin
        f_cen_p = 1'b0;
        f_a_p   = p_q + ADDR_W'(src_row);
        n_phase = 1'b1;
      end
    end
  end

  assign n_inst = {f_acc, f_cen_p, f_wen_p, f_a_p, f_cen_x, 1'b1, f_a_x,
                   f_ofifo_rd, 2'b00, f_l0_rd, f_l0_wr, f_exec, f_load};

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= S_IDLE;
      cnt   <= '0;
      row   <= '0;
      phase <= 1'b0;
      w_q   <= '0;
      a_q   <= '0;
      p_q   <= '0;
      num_q <= '0;
      acc_q <= 1'b0;
      inst  <= IDLE_INST;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= n_state;
      cnt   <= n_cnt;
      row   <= n_row;
      phase <= n_phase;
      inst  <= n_inst;
      busy  <= (n_state != S_IDLE);
      done  <= n_done;
      if (state == S_IDLE && start) begin
        w_q   <= w_base;
        a_q   <= a_base;
        p_q   <= p_base;
        num_q <= num_act;
        acc_q <= acc_en;
      end
    end
  end

endmodule

// File: tb/tb_core_seq_ctrl.sv
// Self-checking bench for core_seq_ctrl: a per-cycle expected instruction
// stream is built from the tile description and compared with the DUT.
module tb_core_seq_ctrl;

  localparam int ROW = 8;
  localparam int COL = 8;
  localparam int VMAX = 4096;
  localparam logic [33:0] IDLE_INST = 34'h1_800C_0000;

  logic        clk = 1'b0;
  logic        reset, start, acc_en, ofifo_valid;
  logic [10:0] w_base, a_base, p_base, num_act;
  logic [33:0] inst;
  logic        busy, done;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [33:0] inst;
    logic        busy;
    logic        done;
  } exp_t;

  exp_t expq[$];
  bit   vpat [0:VMAX-1];

  always #5 clk = ~clk;

  core_seq_ctrl #(.ROW(ROW), .COL(COL), .ADDR_W(11), .CNT_W(11)) dut (
    .clk(clk), .reset(reset), .start(start),
    .w_base(w_base), .a_base(a_base), .p_base(p_base),
    .num_act(num_act), .acc_en(acc_en), .ofifo_valid(ofifo_valid),
    .inst(inst), .busy(busy), .done(done)
  );

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] timeout");
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic void push(input logic [33:0] i, input logic b, input logic d);
    exp_t e;
    e.inst = i;
    e.busy = b;
    e.done = d;
    expq.push_back(e);
  endfunction

  function automatic logic [33:0] xmemRead(input logic [10:0] a, input bit l0wr);
    logic [33:0] v = IDLE_INST;
    v[19]   = 1'b0;
    v[17:7] = a;
    v[2]    = l0wr;
    return v;
  endfunction

  function automatic logic [33:0] pmemAccess(input logic [10:0] a, input bit wr, input bit acc);
    logic [33:0] v = IDLE_INST;
    v[32]    = 1'b0;
    v[30:20] = a;
    if (wr) begin
      v[31] = 1'b0;
      v[6]  = 1'b1;
      v[33] = acc;
    end
    return v;
  endfunction

  // Expected stream: entry i is the bus in the i+1-th cycle after start is taken.
  // The drain row decision for entry i uses the valid level driven before it.
  task automatic buildModel(input logic [10:0] w, input logic [10:0] a, input logic [10:0] p,
                            input int n, input bit acc);
    logic [33:0] v;
    logic [10:0] ad;
    expq.delete();
    for (int k = 0; k < ROW; k++) begin
      ad = w + 11'(k);
      push(xmemRead(ad, k > 0), 1'b1, 1'b0);
    end
    for (int i = 0; i < ROW + COL - 1; i++) begin
      v = IDLE_INST;
      v[0] = 1'b1;
      v[3] = (i < ROW);
      v[2] = (i == 0);
      push(v, 1'b1, 1'b0);
    end
    if (n > 0) begin
      for (int j = 0; j < n; j++) begin
        ad = a + 11'(j);
        push(xmemRead(ad, j > 0), 1'b1, 1'b0);
      end
      for (int i = 0; i < n; i++) begin
        v = IDLE_INST;
        v[3] = 1'b1;
        v[1] = 1'b1;
        v[2] = (i == 0);
        push(v, 1'b1, 1'b0);
      end
      for (int j = 0; j < n; j++) begin
        ad = p + 11'(j);
        while (!vpat[expq.size()] && expq.size() < VMAX - 8) push(IDLE_INST, 1'b1, 1'b0);
        if (acc) begin
          push(pmemAccess(ad, 1'b0, 1'b1), 1'b1, 1'b0);
          push(pmemAccess(ad, 1'b1, 1'b1), 1'b1, 1'b0);
        end else begin
          push(pmemAccess(ad, 1'b1, 1'b0), 1'b1, 1'b0);
        end
      end
    end
    push(IDLE_INST, 1'b1, 1'b1);
    push(IDLE_INST, 1'b0, 1'b0);
  endtask

  // mode 0: always valid, 1: random, 2: valid except five cycles early in drain
  task automatic setValid(input int mode, input int n);
    int ds;
    ds = ROW + (ROW + COL - 1) + 2 * n + 1;
    for (int i = 0; i < VMAX; i++) begin
      case (mode)
        1:       vpat[i] = ($urandom_range(0, 2) != 0) || (i > VMAX - 512);
        2:       vpat[i] = !(i >= ds + 1 && i <= ds + 5);
        default: vpat[i] = 1'b1;
      endcase
    end
  endtask

  task automatic applyStimulus(input logic [10:0] w, input logic [10:0] a, input logic [10:0] p,
                               input int n, input bit acc, input int vmode, input int abort_at);
    int loads = 0, execs = 0, dones = 0, pmems = 0, ofrds = 0;
    setValid(vmode, n);
    buildModel(w, a, p, n, acc);
    @(negedge clk);
    start       = 1'b1;
    w_base      = w;
    a_base      = a;
    p_base      = p;
    num_act     = 11'(n);
    acc_en      = acc;
    ofifo_valid = vpat[0];
    for (int t = 1; t <= expq.size(); t++) begin
      @(negedge clk);
      checkOutput("inst", inst, expq[t-1].inst);
      checkOutput("busy", busy, expq[t-1].busy);
      checkOutput("done", done, expq[t-1].done);
      loads += inst[0];
      execs += inst[1];
      dones += done;
      pmems += !inst[32];
      ofrds += inst[6];
      if (t == abort_at) begin
        reset = 1'b0;
        start = 1'b0;
        @(negedge clk);
        checkOutput("rst_inst", inst, IDLE_INST);
        checkOutput("rst_busy", busy, 1'b0);
        checkOutput("rst_done", done, 1'b0);
        reset = 1'b1;
        for (int k = 0; k < 4; k++) begin
          ofifo_valid = 1'b1;
          @(negedge clk);
          checkOutput("post_rst_inst", inst, IDLE_INST);
          checkOutput("post_rst_busy", busy, 1'b0);
        end
        return;
      end
      if (t < expq.size()) begin
        start   = ($urandom_range(0, 3) == 0);
        w_base  = 11'($urandom);
        a_base  = 11'($urandom);
        p_base  = 11'($urandom);
        num_act = 11'($urandom);
        acc_en  = 1'($urandom);
      end else begin
        start = 1'b0;
      end
      ofifo_valid = vpat[t];
    end
    checkOutput("load_cycles", loads, ROW + COL - 1);
    checkOutput("exec_cycles", execs, n);
    checkOutput("done_pulses", dones, 1);
    checkOutput("pmem_cycles", pmems, acc ? 2 * n : n);
    checkOutput("ofifo_rd_cycles", ofrds, n);
  endtask

  initial begin
    reset       = 1'b0;
    start       = 1'b0;
    acc_en      = 1'b0;
    ofifo_valid = 1'b0;
    w_base      = '0;
    a_base      = '0;
    p_base      = '0;
    num_act     = '0;
    repeat (2) @(negedge clk);
    checkOutput("reset_inst", inst, IDLE_INST);
    checkOutput("reset_busy", busy, 1'b0);
    checkOutput("reset_done", done, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("idle_inst", inst, IDLE_INST);

    $display("[TB] weight fetch and load, num_act=4 overwrite");
    applyStimulus(11'h010, 11'h200, 11'h300, 4, 1'b0, 0, -1);
    $display("[TB] activation address wrap");
    applyStimulus(11'h123, 11'h7FE, 11'h050, 4, 1'b0, 0, -1);
    $display("[TB] accumulate drain at 0x100");
    applyStimulus(11'h000, 11'h040, 11'h100, 3, 1'b1, 0, -1);
    $display("[TB] ofifo_valid gap mid-drain");
    applyStimulus(11'h400, 11'h500, 11'h600, 4, 1'b1, 2, -1);
    $display("[TB] empty tile");
    applyStimulus(11'h7FC, 11'h001, 11'h002, 0, 1'b1, 0, -1);
    $display("[TB] reset during execute");
    applyStimulus(11'h011, 11'h022, 11'h7FF, 6, 1'b1, 0, ROW + (ROW + COL - 1) + 6 + 3);
    $display("[TB] randomized tiles");
    for (int r = 0; r < 12; r++) begin
      applyStimulus(11'($urandom), 11'($urandom), 11'($urandom),
                    $urandom_range(0, 20), 1'($urandom), 1, -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
